// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter for the register file's single write port (ALU vs load path).
// Define WB_SCOREBOARD_EN to build the pending-write scoreboard behind the busy output.
module regfile_wb_arbiter #(
    parameter  int XLEN  = 64,
    parameter  int NREG  = 32,
    localparam int IDX_W = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             reset_n,

    input  logic             alu_valid,
    output logic             alu_ready,
    input  logic [IDX_W-1:0] alu_rd,
    input  logic [XLEN-1:0]  alu_data,

    input  logic             mem_valid,
    output logic             mem_ready,
    input  logic [IDX_W-1:0] mem_rd,
    input  logic [XLEN-1:0]  mem_data,

    output logic             reg_write,
    output logic [IDX_W-1:0] w_reg,
    output logic [XLEN-1:0]  w_data,

    input  logic             claim_valid,
    input  logic [IDX_W-1:0] claim_rd,
    output logic [NREG-1:0]  busy
);

    logic             prio_q, prio_d;
    logic             reg_write_q, reg_write_d;
    logic [IDX_W-1:0] w_reg_q, w_reg_d;
    logic [XLEN-1:0]  w_data_q, w_data_d;

    logic             alu_gnt, mem_gnt, xfer;
    logic [IDX_W-1:0] sel_rd;
    logic [XLEN-1:0]  sel_data;

    // Readies stay low while reset is held so nothing is consumed during reset.
    always_comb begin
        alu_gnt = 1'b0;
        mem_gnt = 1'b0;
        if (reset_n) begin
            if (alu_valid && mem_valid) begin
                alu_gnt = ~prio_q;
                mem_gnt = prio_q;
            end else begin
                alu_gnt = alu_valid;
                mem_gnt = mem_valid;
            end
        end
    end

    assign alu_ready = alu_gnt;
    assign mem_ready = mem_gnt;
    assign xfer      = alu_gnt | mem_gnt;
    assign sel_rd    = mem_gnt ? mem_rd   : alu_rd;
    assign sel_data  = mem_gnt ? mem_data : alu_data;

    // Priority always passes to whichever requester was not just served.
    always_comb begin
        prio_d = prio_q;
        if (alu_gnt) begin
            prio_d = 1'b1;
        end else if (mem_gnt) begin
            prio_d = 1'b0;
        end
    end

    always_comb begin
        reg_write_d = 1'b0;
        w_reg_d     = w_reg_q;
        w_data_d    = w_data_q;
        if (xfer && (sel_rd != '0)) begin
            reg_write_d = 1'b1;
            w_reg_d     = sel_rd;
            w_data_d    = sel_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prio_q      <= 1'b0;
            reg_write_q <= 1'b0;
            w_reg_q     <= '0;
            w_data_q    <= '0;
        end else begin
            prio_q      <= prio_d;
            reg_write_q <= reg_write_d;
            w_reg_q     <= w_reg_d;
            w_data_q    <= w_data_d;
        end
    end

    assign reg_write = reg_write_q;
    assign w_reg     = w_reg_q;
    assign w_data    = w_data_q;

`ifdef WB_SCOREBOARD_EN
    logic [NREG-1:0] busy_q, busy_d;

    // Claim is applied after the clear so a same-edge claim of the written register wins.
    always_comb begin
        busy_d = busy_q;
        if (xfer) begin
            busy_d[sel_rd] = 1'b0;
        end
        if (claim_valid) begin
            busy_d[claim_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;
`else
    logic unused_claim;

    assign unused_claim = claim_valid ^ (^claim_rd);
    assign busy         = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios followed by randomized
// protocol-compliant traffic, compared against a transaction-level reference model.
module tb_regfile_wb_arbiter;

    localparam int XLEN = 64;
    localparam int NREG = 32;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            alu_valid, mem_valid, claim_valid;
    logic            alu_ready, mem_ready;
    logic [4:0]      alu_rd, mem_rd, claim_rd;
    logic [XLEN-1:0] alu_data, mem_data;
    logic            reg_write;
    logic [4:0]      w_reg;
    logic [XLEN-1:0] w_data;
    logic [NREG-1:0] busy;

    int errorCount = 0;
    int checkCount = 0;

    // Reference model: who was served last, the expected write port, and the pending set.
    bit              aluServedLast;
    bit              expRegWrite;
    logic [4:0]      expWReg;
    logic [XLEN-1:0] expWData;
    bit              expBusy [NREG];

    regfile_wb_arbiter #(.XLEN(XLEN), .NREG(NREG)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .reg_write   (reg_write),
        .w_reg       (w_reg),
        .w_data      (w_data),
        .claim_valid (claim_valid),
        .claim_rd    (claim_rd),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [XLEN-1:0] observed,
                               input logic [XLEN-1:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [NREG-1:0] modelBusyVector();
        logic [NREG-1:0] v;
        for (int r = 0; r < NREG; r++) begin
            v[r] = expBusy[r];
        end
        return v;
    endfunction

    task automatic modelReset();
        aluServedLast = 1'b0;
        expRegWrite   = 1'b0;
        expWReg       = '0;
        expWData      = '0;
        for (int r = 0; r < NREG; r++) begin
            expBusy[r] = 1'b0;
        end
    endtask

    // One cycle: drive at negedge, check readies mid-cycle, advance the model at the
    // rising edge, then check the registered outputs just after it.
    task automatic applyStimulus(input bit av, input logic [4:0] ard, input logic [XLEN-1:0] adata,
                                 input bit mv, input logic [4:0] mrd, input logic [XLEN-1:0] mdata,
                                 input bit cv, input logic [4:0] crd,
                                 output bit gotAlu, output bit gotMem,
                                 output bit modelAlu, output bit modelMem);
        logic [4:0] winRd;
        logic [XLEN-1:0] winData;
        @(negedge clk);
        alu_valid   = av;
        alu_rd      = ard;
        alu_data    = adata;
        mem_valid   = mv;
        mem_rd      = mrd;
        mem_data    = mdata;
        claim_valid = cv;
        claim_rd    = crd;
        #1;
        if (av && mv) begin
            modelAlu = aluServedLast ? 1'b0 : 1'b1;
            modelMem = !modelAlu;
        end else begin
            modelAlu = av;
            modelMem = mv;
        end
        gotAlu = alu_ready;
        gotMem = mem_ready;
        checkOutput("alu_ready", {63'd0, alu_ready}, {63'd0, modelAlu});
        checkOutput("mem_ready", {63'd0, mem_ready}, {63'd0, modelMem});
        @(posedge clk);
        winRd   = modelMem ? mrd : ard;
        winData = modelMem ? mdata : adata;
        if (modelAlu) aluServedLast = 1'b1;
        if (modelMem) aluServedLast = 1'b0;
        expRegWrite = (modelAlu || modelMem) && (winRd != 0);
        if (expRegWrite) begin
            expWReg  = winRd;
            expWData = winData;
        end
`ifdef WB_SCOREBOARD_EN
        if (modelAlu || modelMem) expBusy[winRd] = 1'b0;
        if (cv && crd != 0) expBusy[crd] = 1'b1;
`endif
        #1;
        checkOutput("reg_write", {63'd0, reg_write}, {63'd0, expRegWrite});
        if (expRegWrite) begin
            checkOutput("w_reg", {59'd0, w_reg}, {59'd0, expWReg});
            checkOutput("w_data", w_data, expWData);
        end
        checkOutput("busy", {32'd0, busy}, {32'd0, modelBusyVector()});
    endtask

    task automatic idleInputs();
        alu_valid   = 1'b0;
        alu_rd      = '0;
        alu_data    = '0;
        mem_valid   = 1'b0;
        mem_rd      = '0;
        mem_data    = '0;
        claim_valid = 1'b0;
        claim_rd    = '0;
    endtask

    initial begin
        bit ga, gm, ma, mm;
        bit aluPend, memPend;
        logic [4:0] aRd, mRd;
        logic [XLEN-1:0] aData, mData;

        idleInputs();
        modelReset();
        reset_n = 1'b0;
        alu_valid = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_alu_ready", {63'd0, alu_ready}, 64'd0);
        checkOutput("rst_reg_write", {63'd0, reg_write}, 64'd0);
        checkOutput("rst_w_reg", {59'd0, w_reg}, 64'd0);
        checkOutput("rst_w_data", w_data, 64'd0);
        checkOutput("rst_busy", {32'd0, busy}, 64'd0);
        idleInputs();
        @(negedge clk);
        reset_n = 1'b1;

        // Contention from a fresh reset: strict alternation starting with ALU.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 5'd1, 64'h1000 + 64'(i), 1, 5'd2, 64'h2000 + 64'(i), 0, 0,
                          ga, gm, ma, mm);
            checkOutput("cont_alu_gnt", {63'd0, ga}, (i % 2 == 0) ? 64'd1 : 64'd0);
            checkOutput("cont_one_hot", {63'd0, ga & gm}, 64'd0);
            checkOutput("cont_w_reg", {59'd0, w_reg}, (i % 2 == 0) ? 64'd1 : 64'd2);
        end
        idleInputs();

        applyStimulus(1, 5'd3, 64'hDEAD_BEEF_0000_0001, 0, 0, 0, 0, 0, ga, gm, ma, mm);
        checkOutput("single_ready", {63'd0, ga}, 64'd1);
        checkOutput("single_w_reg", {59'd0, w_reg}, 64'd3);
        checkOutput("single_w_data", w_data, 64'hDEAD_BEEF_0000_0001);

        applyStimulus(0, 0, 0, 1, 5'd0, 64'hFF, 0, 0, ga, gm, ma, mm);
        checkOutput("x0_ready", {63'd0, gm}, 64'd1);
        checkOutput("x0_reg_write", {63'd0, reg_write}, 64'd0);

        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd7, ga, gm, ma, mm);
`ifdef WB_SCOREBOARD_EN
        checkOutput("claim7_busy", {63'd0, busy[7]}, 64'd1);
`endif
        applyStimulus(1, 5'd7, 64'h77, 0, 0, 0, 0, 0, ga, gm, ma, mm);
        checkOutput("clear7_busy", {63'd0, busy[7]}, 64'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd0, ga, gm, ma, mm);
        checkOutput("claim0_busy", {32'd0, busy}, 64'd0);

        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd9, ga, gm, ma, mm);
        applyStimulus(1, 5'd9, 64'h99, 0, 0, 0, 1, 5'd9, ga, gm, ma, mm);
`ifdef WB_SCOREBOARD_EN
        checkOutput("setwins_busy9", {63'd0, busy[9]}, 64'd1);
`endif
        applyStimulus(0, 0, 0, 1, 5'd9, 64'h9A, 0, 0, ga, gm, ma, mm);

        // Mid-stream reset with a write in flight and a pending claim; ALU served last.
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd5, ga, gm, ma, mm);
        applyStimulus(1, 5'd6, 64'h66, 0, 0, 0, 0, 0, ga, gm, ma, mm);
        checkOutput("pre_rst_reg_write", {63'd0, reg_write}, 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        modelReset();
        checkOutput("async_reg_write", {63'd0, reg_write}, 64'd0);
        checkOutput("async_w_reg", {59'd0, w_reg}, 64'd0);
        checkOutput("async_w_data", w_data, 64'd0);
        checkOutput("async_busy", {32'd0, busy}, 64'd0);
        idleInputs();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus(1, 5'd4, 64'h44, 1, 5'd8, 64'h88, 0, 0, ga, gm, ma, mm);
        checkOutput("post_rst_alu_first", {63'd0, ga}, 64'd1);

        // Random traffic: each requester keeps its request until the model grants it.
        aluPend = 0;
        memPend = 0;
        aRd = '0; mRd = '0; aData = '0; mData = '0;
        for (int i = 0; i < 300; i++) begin
            bit cv;
            logic [4:0] crd;
            if (!aluPend && $urandom_range(0, 99) < 60) begin
                aluPend = 1;
                aRd     = 5'($urandom_range(0, 31));
                aData   = {$urandom, $urandom};
            end
            if (!memPend && $urandom_range(0, 99) < 50) begin
                memPend = 1;
                mRd     = 5'($urandom_range(0, 31));
                mData   = {$urandom, $urandom};
            end
            cv  = ($urandom_range(0, 99) < 30);
            crd = 5'($urandom_range(0, 31));
            applyStimulus(aluPend, aRd, aData, memPend, mRd, mData, cv, crd, ga, gm, ma, mm);
            checkOutput("rand_one_hot", {63'd0, ga & gm}, 64'd0);
            if (ma) aluPend = 0;
            if (mm) memPend = 0;
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
